// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-width helper for the synchronous FIFO slice.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 16;

    // Address width for a power-of-two depth; a depth of 1 still needs one bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage, one synchronous write port and one read port.
// SYNC_FIFO_FWFT_EN selects an asynchronous read port; otherwise the read port is registered.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH,
    parameter int AW    = fifo_ptr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // Storage is deliberately not reset; the control logic never exposes unwritten entries.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic w_unused_rd;

    assign o_rd_data   = r_mem[i_rd_addr];
    assign w_unused_rd = i_rst ^ i_rd_en;
`else
    logic [WIDTH-1:0] r_rd_data;

    // Reading before the same-edge write lands returns the old word when full and both ports hit one entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO: pointers, occupancy, threshold flags and error pulses.
// Build option SYNC_FIFO_FWFT_EN enables first-word-fall-through read data.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEF_WIDTH,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_write_en,
    input  logic [WIDTH-1:0]            i_write_data,
    input  logic                        i_read_en,
    output logic [WIDTH-1:0]            o_read_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_almost_full,
    output logic                        o_almost_empty,
    output logic [fifo_ptr_w(DEPTH):0]  o_count,
    output logic                        o_write_error,
    output logic                        o_read_error
);

    localparam int PTR_DEPTH = fifo_ptr_w(DEPTH);
    localparam logic [PTR_DEPTH:0] C_DEPTH = (PTR_DEPTH+1)'(DEPTH);
    localparam logic [PTR_DEPTH:0] C_AF    = (PTR_DEPTH+1)'(AF_LEVEL);
    localparam logic [PTR_DEPTH:0] C_AE    = (PTR_DEPTH+1)'(AE_LEVEL);
    localparam logic [PTR_DEPTH:0] C_ONE   = (PTR_DEPTH+1)'(1);

    logic [PTR_DEPTH:0] r_wr_ptr;
    logic [PTR_DEPTH:0] r_rd_ptr;
    logic [PTR_DEPTH:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_almost_full;
    logic               r_almost_empty;
    logic               r_write_error;
    logic               r_read_error;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [PTR_DEPTH:0] w_wr_ptr_nxt;
    logic [PTR_DEPTH:0] w_rd_ptr_nxt;
    logic [PTR_DEPTH:0] w_count_nxt;
    logic [WIDTH-1:0]   w_mem_rd_data;

    // A write into a full FIFO is only legal when a read frees the head slot on the same edge.
    always_comb begin
        w_rd_acc     = i_read_en && !r_empty;
        w_wr_acc     = i_write_en && (!r_full || w_rd_acc);
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + C_ONE;
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + C_ONE;
        end
        w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_write_error  <= 1'b0;
            r_read_error   <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == C_DEPTH);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= C_AF);
            r_almost_empty <= (w_count_nxt <= C_AE);
            r_write_error  <= i_write_en && !w_wr_acc;
            r_read_error   <= i_read_en && !w_rd_acc;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[PTR_DEPTH-1:0]),
        .i_wr_data (i_write_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[PTR_DEPTH-1:0]),
        .o_rd_data (w_mem_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Masked while empty so a stale slot never leaks onto the output.
    assign o_read_data = r_empty ? '0 : w_mem_rd_data;
`else
    assign o_read_data = w_mem_rd_data;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;
    assign o_write_error  = r_write_error;
    assign o_read_error   = r_read_error;

`ifndef SYNTHESIS
    a_count_range : assert property (@(posedge i_clk) disable iff (i_rst) r_count <= C_DEPTH);
    a_count_ptrs  : assert property (@(posedge i_clk) disable iff (i_rst) r_count == (r_wr_ptr - r_rd_ptr));
    a_full_empty  : assert property (@(posedge i_clk) disable iff (i_rst) !(r_full && r_empty));
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=16, WIDTH=8); follows SYNC_FIFO_FWFT_EN when defined.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk;
    logic             i_rst;
    logic             i_write_en;
    logic [WIDTH-1:0] i_write_data;
    logic             i_read_en;
    logic [WIDTH-1:0] o_read_data;
    logic             o_full;
    logic             o_empty;
    logic             o_almost_full;
    logic             o_almost_empty;
    logic [4:0]       o_count;
    logic             o_write_error;
    logic             o_read_error;

    int               n_vec;
    int               n_err;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_rd;

    sync_fifo_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_write_en     (i_write_en),
        .i_write_data   (i_write_data),
        .i_read_en      (i_read_en),
        .o_read_data    (o_read_data),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_count        (o_count),
        .o_write_error  (o_write_error),
        .o_read_error   (o_read_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clocked request; expectations come from a queue model of the FIFO behaviour.
    task automatic op(input bit we, input logic [WIDTH-1:0] d, input bit re, input string tag);
        bit rd_acc;
        bit wr_acc;
        int sz;
        rd_acc = re && (q.size() > 0);
        wr_acc = we && ((q.size() < DEPTH) || rd_acc);
`ifdef SYNC_FIFO_FWFT_EN
        if (q.size() > 0) chk({tag, "_head"}, 32'(o_read_data), 32'(q[0]));
        else              chk({tag, "_head0"}, 32'(o_read_data), 32'(0));
`endif
        i_write_en   = we;
        i_write_data = d;
        i_read_en    = re;
        step();
        i_write_en   = 1'b0;
        i_read_en    = 1'b0;
        if (rd_acc) last_rd = q.pop_front();
        if (wr_acc) q.push_back(d);
        sz = q.size();
`ifndef SYNC_FIFO_FWFT_EN
        chk({tag, "_rdata"}, 32'(o_read_data), 32'(last_rd));
`endif
        chk({tag, "_count"}, 32'(o_count), 32'(sz));
        chk({tag, "_full"},  32'(o_full),  32'(sz == DEPTH));
        chk({tag, "_empty"}, 32'(o_empty), 32'(sz == 0));
        chk({tag, "_af"},    32'(o_almost_full),  32'(sz >= AF));
        chk({tag, "_ae"},    32'(o_almost_empty), 32'(sz <= AE));
        chk({tag, "_werr"},  32'(o_write_error),  32'(we && !wr_acc));
        chk({tag, "_rerr"},  32'(o_read_error),   32'(re && !rd_acc));
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        last_rd      = '0;
        i_rst        = 1'b1;
        i_write_en   = 1'b0;
        i_write_data = '0;
        i_read_en    = 1'b0;
        step();
        step();
        chk("rst_count", 32'(o_count), 32'(0));
        chk("rst_empty", 32'(o_empty), 32'(1));
        chk("rst_ae",    32'(o_almost_empty), 32'(1));
        chk("rst_full",  32'(o_full), 32'(0));
        chk("rst_af",    32'(o_almost_full), 32'(0));
        chk("rst_rdata", 32'(o_read_data), 32'(0));
        chk("rst_werr",  32'(o_write_error), 32'(0));
        chk("rst_rerr",  32'(o_read_error), 32'(0));
        i_rst = 1'b0;

        // Fill 0x01..0x10, almost_full from the 14th write, then overflow once.
        for (int i = 1; i <= 16; i++) begin
            op(1'b1, WIDTH'(i), 1'b0, "fill");
            chk("fill_af_hand", 32'(o_almost_full), 32'(i >= 14));
        end
        chk("full16", 32'(o_full), 32'(1));
        chk("count16", 32'(o_count), 32'(16));
        op(1'b1, 8'h99, 1'b0, "w17");
        chk("w17_err", 32'(o_write_error), 32'(1));
        chk("w17_count", 32'(o_count), 32'(16));
        op(1'b0, 8'h00, 1'b0, "w17_idle");
        chk("w17_err_clear", 32'(o_write_error), 32'(0));

        // Drain in order, then underflow once.
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_first", 32'(o_read_data), 32'(8'h01));
`endif
        for (int i = 1; i <= 16; i++) begin
            op(1'b0, 8'h00, 1'b1, "drain");
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain_hand", 32'(o_read_data), 32'(i));
`endif
        end
        chk("drain_empty", 32'(o_empty), 32'(1));
        op(1'b0, 8'h00, 1'b1, "rd_extra");
        chk("rd_extra_err", 32'(o_read_error), 32'(1));
`ifndef SYNC_FIFO_FWFT_EN
        chk("rd_hold", 32'(o_read_data), 32'(8'h10));
`endif
        op(1'b0, 8'h00, 1'b0, "rd_idle");
        chk("rd_err_clear", 32'(o_read_error), 32'(0));

        // Full with simultaneous write and read.
        for (int i = 0; i < 16; i++) op(1'b1, WIDTH'(8'h21 + i), 1'b0, "fill2");
        op(1'b1, 8'hAA, 1'b1, "full_rw");
        chk("full_rw_count", 32'(o_count), 32'(16));
        chk("full_rw_werr", 32'(o_write_error), 32'(0));
        chk("full_rw_rerr", 32'(o_read_error), 32'(0));
`ifndef SYNC_FIFO_FWFT_EN
        chk("full_rw_oldest", 32'(o_read_data), 32'(8'h21));
`endif
        for (int i = 0; i < 17; i++) begin
            if (q.size() > 0) op(1'b0, 8'h00, 1'b1, "drain2");
        end
        chk("drain2_empty", 32'(o_empty), 32'(1));

        // Empty with simultaneous write and read.
        op(1'b1, 8'h55, 1'b1, "empty_rw");
        chk("empty_rw_rerr", 32'(o_read_error), 32'(1));
        chk("empty_rw_count", 32'(o_count), 32'(1));
        op(1'b0, 8'h00, 1'b1, "rd55");
`ifndef SYNC_FIFO_FWFT_EN
        chk("rd55_data", 32'(o_read_data), 32'(8'h55));
`endif

        // Interleaved traffic wrapping the pointers at least twice.
        for (int k = 0; k < 40; k++) begin
            op(1'b1, WIDTH'(8'h40 + k), (k % 4) != 0, "mix");
            chk("mix_le16", 32'(o_count <= 5'd16), 32'(1));
        end
        for (int i = 0; i < 17; i++) begin
            if (q.size() > 0) op(1'b0, 8'h00, 1'b1, "mix_drain");
        end

        // Asynchronous reset in the middle of traffic with seven entries held.
        for (int i = 0; i < 7; i++) op(1'b1, WIDTH'(8'h70 + i), 1'b0, "pre_rst");
        chk("pre_rst_count", 32'(o_count), 32'(7));
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_empty", 32'(o_empty), 32'(1));
        chk("arst_count", 32'(o_count), 32'(0));
        chk("arst_rdata", 32'(o_read_data), 32'(0));
        chk("arst_werr", 32'(o_write_error), 32'(0));
        i_write_en   = 1'b1;
        i_write_data = 8'hEE;
        i_read_en    = 1'b1;
        step();
        chk("in_rst_count", 32'(o_count), 32'(0));
        chk("in_rst_werr", 32'(o_write_error), 32'(0));
        chk("in_rst_rerr", 32'(o_read_error), 32'(0));
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        i_rst      = 1'b0;
        q.delete();
        last_rd    = '0;
        op(1'b0, 8'h00, 1'b0, "post_rst");
        op(1'b1, 8'h3C, 1'b0, "post_rst_w");
        op(1'b0, 8'h00, 1'b1, "post_rst_r");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 Derived constant PTR_DEPTH = $clog2(DEPTH).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 write_en  input  1  write request.
REQ-009 write_data  input  WIDTH  word to store.
REQ-010 read_en  input  1  read request.
REQ-011 read_data  output  WIDTH  read word.
REQ-012 full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  PTR_DEPTH+1  current occupancy, 0..DEPTH.
REQ-015 write_error, read_error  output  1 each  one-cycle pulse on rejected request.

Function
REQ-016 Pointers wr_ptr/rd_ptr SHALL be PTR_DEPTH+1 bits; low bits address memory, MSB is wrap bit; both wrap modulo 2*DEPTH.
REQ-017 Write accepted when write_en and (!full or read accepted same cycle); stores write_data at wr_ptr, wr_ptr+1.
REQ-018 Read accepted when read_en and !empty; rd_ptr+1.
REQ-019 Full with write_en and read_en: both accepted, count unchanged, no error.
REQ-020 Empty with write_en and read_en: write accepted, read rejected, read_error=1 next cycle.
REQ-021 Rejected write: memory and wr_ptr unchanged, write_error=1 for exactly the following cycle.
REQ-022 Rejected read: rd_ptr and read_data unchanged, read_error=1 for exactly the following cycle.
REQ-023 count, full, empty, almost_full, almost_empty SHALL be registered and reflect accepted operations on the edge they occur (valid the cycle after).
REQ-024 count = wr_ptr - rd_ptr; full = (count==DEPTH); empty = (count==0).
REQ-025 Non-FWFT: read_data updates to the popped word one cycle after an accepted read; holds otherwise.
REQ-026 Pointer wrap from DEPTH-1 to 0 in low bits SHALL toggle MSB with no bubble or data loss.

Reset
REQ-027 rst SHALL immediately clear wr_ptr, rd_ptr, count, read_data, full, almost_full, write_error, read_error to 0 and set empty=1, almost_empty=1 (AE_LEVEL>=0).
REQ-028 Memory contents SHALL NOT be reset; stale data is never observable.
REQ-029 rst asserted mid-traffic SHALL discard all entries; requests during rst are ignored without error pulses.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN: defined -> first-word-fall-through; read_data shows head entry whenever !empty, read_en pops and next entry appears the following cycle; first write to empty FIFO visible on read_data one cycle after write.
REQ-031 Without SYNC_FIFO_FWFT_EN: standard mode per REQ-025; flags and errors identical in both modes.

Structure
REQ-032 Package fifo_pkg SHALL hold shared default constants (default WIDTH, DEPTH) and any pointer-width helper function.
REQ-033 Storage SHALL be a sub-module fifo_mem: DEPTH x WIDTH, one synchronous write port, one read port (registered for non-FWFT, asynchronous for FWFT).
REQ-034 Control (pointers, count, flags, errors) SHALL live in sync_fifo_param top.

Verification
REQ-035 Reset then write 16 words 0x01..0x10 (DEPTH=16) -> full=1, count=16, almost_full=1 from 14th write; 17th write -> write_error pulse, count stays 16.
REQ-036 Read 16 words from full -> data 0x01..0x10 in order, empty=1 after last; extra read -> read_error pulse, read_data holds 0x10.
REQ-037 Full plus simultaneous write 0xAA/read -> read returns oldest word, count stays 16, no errors.
REQ-038 Empty plus simultaneous write 0x55/read -> read_error pulse, count=1, subsequent read returns 0x55.
REQ-039 40 interleaved writes/reads crossing wrap twice -> scoreboard order match, count never exceeds 16.
REQ-040 rst pulse asynchronously at count=7 -> empty=1, count=0 immediately, no error pulse; with SYNC_FIFO_FWFT_EN repeat REQ-036 checking read_data=0x01 before first read_en.
